// File: rtl/regfile_pkg.sv
// Shared opcode constants and FSM encodings for the register-file controller.
package regfile_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LDI    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_MOV    = 3'b110;
  localparam logic [2:0] OP_CLRALL = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4
  } state_e;

  // Only the arithmetic/logic opcodes touch zero_flag and carry_flag.
  function automatic logic sets_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU: opcode and two operands in, value plus carry/zero out.
import regfile_pkg::*;

module regfile_alu #(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] value,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // The extra MSB of the widened difference is the borrow (a < b).
    diff  = {1'b0, a} - {1'b0, b};
    value = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        value = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        value = diff[DATA_W-1:0];
        carry = diff[DATA_W];
      end
      OP_AND:  value = a & b;
      OP_OR:   value = a | b;
      OP_MOV:  value = a;
      default: value = '0;
    endcase
    zero = (value == '0);
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Sequences 16-bit instructions into read / execute / write cycles on an
// external register file; dbg_state exposes the FSM for checkers.
import regfile_pkg::*;

module regfile_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_readreg1,
  output logic [ADDR_W-1:0] rf_readreg2,
  output logic [ADDR_W-1:0] rf_writereg,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_op,
  output logic              rf_clr,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: an instruction transfers on a posedge where instr_valid and
  // instr_ready are both 1; instr_ready is 1 only in IDLE, and a valid offered
  // while not ready is ignored until the block returns to IDLE.
  state_e            state, state_n;
  logic              accept;
  logic [2:0]        op_q, rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] val_q;
  logic              c_q, z_q;
  logic [DATA_W-1:0] alu_value;
  logic              alu_carry, alu_zero;

  assign accept    = instr_valid && (state == IDLE);
  assign dbg_state = state;

  regfile_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op_q),
    .a     (rf_read1),
    .b     (rf_read2),
    .value (alu_value),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    rf_op       = 1'b0;
    rf_clr      = 1'b0;
    rf_readreg1 = '0;
    rf_readreg2 = '0;
    rf_writereg = '0;
    rf_data     = '0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (instr[15:13])
            OP_NOP:    state_n = IDLE;
            OP_LDI:    state_n = WRITE;
            OP_CLRALL: state_n = CLEAR;
            default:   state_n = READ;
          endcase
        end
      end
      READ: begin
        rf_readreg1 = ADDR_W'(rs1_q);
        rf_readreg2 = ADDR_W'(rs2_q);
        state_n     = EXEC;
      end
      EXEC: state_n = WRITE;
      WRITE: begin
        rf_op       = 1'b1;
        rf_writereg = ADDR_W'(rd_q);
        rf_data     = val_q;
        state_n     = IDLE;
      end
      CLEAR: begin
        rf_clr  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Flags are committed together with result when the write retires, so an
  // aborted instruction leaves no architectural trace.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      val_q      <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q  <= instr[15:13];
        rd_q  <= instr[12:10];
        rs1_q <= instr[9:7];
        rs2_q <= instr[6:4];
        if (instr[15:13] == OP_NOP) done  <= 1'b1;
        if (instr[15:13] == OP_LDI) val_q <= DATA_W'(instr[7:0]);
      end
      if (state == EXEC) begin
        val_q <= alu_value;
        c_q   <= alu_carry;
        z_q   <= alu_zero;
      end
      if (state == WRITE) begin
        result <= val_q;
        done   <= 1'b1;
        if (sets_flags(op_q)) begin
          carry_flag <= c_q;
          zero_flag  <= z_q;
        end
      end
      if (state == CLEAR) begin
        result <= '0;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a behavioural register file.
module tb_regfile_ctrl;
  import regfile_pkg::*;

  logic        clk;
  logic        clr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  rf_readreg1, rf_readreg2, rf_writereg;
  logic [7:0]  rf_data;
  logic        rf_op, rf_clr;
  logic [7:0]  rf_read1, rf_read2;
  logic [7:0]  result;
  logic        zero_flag, carry_flag, done;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int clr_cnt = 0;
  int done_cnt = 0;
  logic [2:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  logic [7:0] rf_mem [8];

  regfile_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .clr(clr), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
    .rf_writereg(rf_writereg), .rf_data(rf_data), .rf_op(rf_op), .rf_clr(rf_clr),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: writes on negedge, reads registered on posedge.
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(negedge clk) begin
    if (rf_clr) for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    else if (rf_op) rf_mem[rf_writereg] <= rf_data;
  end
  always @(posedge clk) begin
    rf_read1 <= rf_mem[rf_readreg1];
    rf_read2 <= rf_mem[rf_readreg2];
  end

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rf_op) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= rf_writereg;
      last_wd <= rf_data;
    end
    if (rf_clr) clr_cnt  <= clr_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {OP_LDI, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  // Driver: offer w, wait (bounded) for acceptance, then measure cycles to done.
  task automatic run_instr(input string tag, input logic [15:0] w, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, instr_ready, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic chk_write(input string tag, input int w0, input logic [2:0] wa, input logic [7:0] wd);
    chk({tag, "_wrcnt"}, wr_cnt - w0, 1);
    chk({tag, "_wa"}, last_wa, wa);
    chk({tag, "_wd"}, last_wd, wd);
  endtask

  initial begin
    int w0, c0, d0;
    clr = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_rf_op", rf_op, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    clr = 1'b0;

    w0 = wr_cnt;
    run_instr("ldi_r2", enc_ldi(3'd2, 8'h5A), 2);
    chk_write("ldi_r2", w0, 3'd2, 8'h5A);
    chk("ldi_r2_result", result, 8'h5A);

    run_instr("ldi_r1", enc_ldi(3'd1, 8'hF0), 2);
    run_instr("ldi_r2b", enc_ldi(3'd2, 8'h20), 2);
    chk("ldi_r2b_result", result, 8'h20);

    w0 = wr_cnt;
    run_instr("add", enc_r(OP_ADD, 3'd3, 3'd1, 3'd2), 4);
    chk_write("add", w0, 3'd3, 8'h10);
    chk("add_carry", carry_flag, 1);
    chk("add_zero", zero_flag, 0);
    chk("add_result", result, 8'h10);

    w0 = wr_cnt;
    run_instr("sub", enc_r(OP_SUB, 3'd4, 3'd2, 3'd1), 4);
    chk_write("sub", w0, 3'd4, 8'h30);
    chk("sub_carry", carry_flag, 1);
    chk("sub_zero", zero_flag, 0);

    w0 = wr_cnt;
    run_instr("subz", enc_r(OP_SUB, 3'd5, 3'd1, 3'd1), 4);
    chk_write("subz", w0, 3'd5, 8'h00);
    chk("subz_zero", zero_flag, 1);
    chk("subz_carry", carry_flag, 0);

    w0 = wr_cnt;
    c0 = clr_cnt;
    run_instr("clrall", {OP_CLRALL, 13'h0}, 2);
    chk("clrall_pulses", clr_cnt - c0, 1);
    chk("clrall_nowrite", wr_cnt - w0, 0);
    chk("clrall_result", result, 0);

    w0 = wr_cnt;
    run_instr("mov", enc_r(OP_MOV, 3'd6, 3'd1, 3'd0), 4);
    chk_write("mov", w0, 3'd6, 8'h00);

    w0 = wr_cnt;
    run_instr("nop", 16'h0000, 1);
    chk("nop_nowrite", wr_cnt - w0, 0);

    run_instr("ldi_r1c", enc_ldi(3'd1, 8'h0F), 2);
    chk("ldi_keeps_zero", zero_flag, 1);

    // Back-to-back: valid held high while busy
    w0 = wr_cnt;
    @(negedge clk);
    instr = enc_r(OP_OR, 3'd2, 3'd1, 3'd1);
    instr_valid = 1'b1;
    chk("b2b_ready0", instr_ready, 1);
    @(posedge clk);
    #1 instr = enc_ldi(3'd3, 8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_busy", instr_ready, 0);
    end
    @(negedge clk);
    chk("b2b_idle", instr_ready, 1);
    chk("b2b_or_done", done, 1);
    chk_write("b2b_or", w0, 3'd2, 8'h0F);
    chk("b2b_or_result", result, 8'h0F);
    chk("b2b_or_zero", zero_flag, 0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 chk("b2b_ldi_done", done, 1);
    chk("b2b_two_writes", wr_cnt - w0, 2);
    chk("b2b_ldi_wa", last_wa, 3'd3);
    chk("b2b_ldi_wd", last_wd, 8'h77);

    w0 = wr_cnt;
    run_instr("and", enc_r(OP_AND, 3'd4, 3'd1, 3'd3), 4);
    chk_write("and", w0, 3'd4, 8'h07);
    chk("and_carry", carry_flag, 0);

    w0 = wr_cnt;
    run_instr("sub_b", enc_r(OP_SUB, 3'd6, 3'd1, 3'd3), 4);
    chk_write("sub_b", w0, 3'd6, 8'h98);
    chk("sub_b_carry", carry_flag, 1);

    // Reset asserted during EXEC of an ADD
    @(negedge clk);
    instr = enc_r(OP_ADD, 3'd5, 3'd3, 3'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre_clr_exec", dbg_state, EXEC);
    w0 = wr_cnt;
    c0 = clr_cnt;
    d0 = done_cnt;
    #2 clr = 1'b1;
    #1;
    chk("clr_ready", instr_ready, 1);
    chk("clr_rf_op", rf_op, 0);
    chk("clr_done", done, 0);
    chk("clr_result", result, 0);
    chk("clr_carry", carry_flag, 0);
    chk("clr_rf_data", rf_data, 0);
    chk("clr_addrs", {rf_readreg1, rf_readreg2, rf_writereg}, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("clr_no_write", wr_cnt - w0, 0);
    chk("clr_no_done", done_cnt - d0, 0);
    chk("clr_no_rfclr", clr_cnt - c0, 0);

    w0 = wr_cnt;
    run_instr("ldi_post", enc_ldi(3'd7, 8'h3C), 2);
    chk_write("ldi_post", w0, 3'd7, 8'h3C);
    chk("ldi_post_result", result, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
